// File: rtl/mor1kx_spr_initiator.sv
// ============================================================================
// Module   : mor1kx_spr_initiator
// Brief    : Single-outstanding SPR bus initiator for mtspr/mfspr requests.
//            Optional access timeout enabled by MOR1KX_SPR_INITIATOR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mor1kx_spr_initiator #(
    parameter int SPR_TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_wdat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdat_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        spr_access_o,
    output logic        spr_we_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    input  logic        spr_bus_ack_i,
    input  logic [31:0] spr_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat_q;
    logic        timeout;

    if ((SPR_TIMEOUT_CYCLES < 1) ||
        (SPR_TIMEOUT_CYCLES > (1 << TIMEOUT_WIDTH) - 1)) begin : g_param_check
        $error("SPR_TIMEOUT_CYCLES out of range for TIMEOUT_WIDTH");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            addr_q <= 16'h0000;
            wdat_q <= 32'h0000_0000;
            rdat_q <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid_i) begin
                we_q   <= req_we_i;
                addr_q <= req_addr_i;
                wdat_q <= req_wdat_i;
            end
            // An ack in the final timeout cycle takes priority over the error.
            if (state == BUS && spr_bus_ack_i) begin
                rdat_q <= we_q ? 32'h0000_0000 : spr_dat_i;
            end else if (timeout) begin
                rdat_q <= 32'h0000_0000;
            end
        end
    end

`ifdef MOR1KX_SPR_INITIATOR_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     err_q;

    assign timeout = (state == BUS) && !spr_bus_ack_i &&
                     (tmo_cnt == TIMEOUT_WIDTH'(SPR_TIMEOUT_CYCLES - 1));

    // Held at zero outside BUS, so every transaction starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state != BUS) begin
                tmo_cnt <= '0;
            end else if (!spr_bus_ack_i) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == BUS && spr_bus_ack_i) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_err_o = err_q;
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid_i) state_nxt = BUS;
            BUS:     if (spr_bus_ack_i || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are gated so no strobe or stale data leaks outside BUS.
    assign req_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign rsp_valid_o  = (state == RESP);
    assign rsp_rdat_o   = rdat_q;
    assign spr_access_o = (state == BUS);
    assign spr_we_o     = (state == BUS) ? we_q   : 1'b0;
    assign spr_addr_o   = (state == BUS) ? addr_q : 16'h0000;
    assign spr_dat_o    = (state == BUS) ? wdat_q : 32'h0000_0000;

endmodule

`default_nettype wire

// File: tb/tb_mor1kx_spr_initiator.sv
// ============================================================================
// Module   : tb_mor1kx_spr_initiator
// Brief    : Directed self-checking bench for mor1kx_spr_initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mor1kx_spr_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [15:0] req_addr_i;
    logic [31:0] req_wdat_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdat_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        spr_access_o;
    logic        spr_we_o;
    logic [15:0] spr_addr_o;
    logic [31:0] spr_dat_o;
    logic        spr_bus_ack_i;
    logic [31:0] spr_dat_i;

    int          n_vec = 0;
    int          n_bad = 0;
    int          ack_after = 100000;
    int          acc_cycles = 0;
    logic [31:0] rd_value = 32'h0;

    always #5 clk = ~clk;

`ifdef MOR1KX_SPR_INITIATOR_TIMEOUT_EN
    mor1kx_spr_initiator #(.SPR_TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
`else
    mor1kx_spr_initiator dut (
`endif
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdat_i(req_wdat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdat_o(rsp_rdat_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .spr_access_o(spr_access_o), .spr_we_o(spr_we_o),
        .spr_addr_o(spr_addr_o), .spr_dat_o(spr_dat_o),
        .spr_bus_ack_i(spr_bus_ack_i), .spr_dat_i(spr_dat_i)
    );

    // Responder: acks combinationally once it has seen ack_after access cycles.
    always @(posedge clk) acc_cycles <= spr_access_o ? acc_cycles + 1 : 0;
    assign spr_bus_ack_i = spr_access_o && (acc_cycles == ack_after);
    assign spr_dat_i     = spr_bus_ack_i ? rd_value : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input string name, input logic we, input logic [15:0] addr,
                           input logic [31:0] wdat, input int wait_n, input logic [31:0] rdv,
                           input int exp_cycles, input logic [31:0] exp_rdat, input logic exp_err);
        int n;
        @(negedge clk);
        ack_after = wait_n;
        rd_value  = rdv;
        check({name, ".ready"}, {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdat_i  = wdat;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_we_i    = 1'($urandom);
        req_addr_i  = 16'($urandom);
        req_wdat_i  = $urandom;
        check({name, ".we"}, {31'b0, spr_we_o}, {31'b0, we});
        check({name, ".addr"}, {16'b0, spr_addr_o}, {16'b0, addr});
        check({name, ".wdat"}, spr_dat_o, wdat);
        n = 0;
        while (spr_access_o && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check({name, ".access_cycles"}, 32'(n), 32'(exp_cycles));
        check({name, ".rsp_valid"}, {31'b0, rsp_valid_o}, 32'd1);
        check({name, ".rdat"}, rsp_rdat_o, exp_rdat);
        check({name, ".err"}, {31'b0, rsp_err_o}, {31'b0, exp_err});
        check({name, ".resp_we_low"}, {31'b0, spr_we_o}, 32'd0);
        check({name, ".resp_dat_low"}, spr_dat_o, 32'd0);
        @(negedge clk);
        check({name, ".rsp_pulse_end"}, {31'b0, rsp_valid_o}, 32'd0);
        check({name, ".idle_busy"}, {31'b0, busy_o}, 32'd0);
        check({name, ".rdat_hold"}, rsp_rdat_o, exp_rdat);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_addr_i = 16'h0;
        req_wdat_i = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset.access", {31'b0, spr_access_o}, 32'd0);
        check("reset.rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("reset.busy", {31'b0, busy_o}, 32'd0);
        check("reset.rdat", rsp_rdat_o, 32'd0);
        check("reset.err", {31'b0, rsp_err_o}, 32'd0);
        check("reset.ready", {31'b0, req_ready_o}, 32'd1);

        run_txn("wr_zero_wait", 1'b1, 16'h4800, 32'hFFFF_0000, 0, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
        run_txn("rd_3_wait", 1'b0, 16'h4802, 32'h0, 3, 32'h0000_0005, 4, 32'h0000_0005, 1'b0);

        // Back-to-back requests with req_valid_i held high throughout.
        @(negedge clk);
        ack_after = 0;
        rd_value = 32'h1111_1111;
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        req_addr_i = 16'h0A01;
        @(negedge clk);
        check("b2b.A_access", {31'b0, spr_access_o}, 32'd1);
        check("b2b.A_bus_ready", {31'b0, req_ready_o}, 32'd0);
        check("b2b.A_addr", {16'b0, spr_addr_o}, 32'h0A01);
        req_addr_i = 16'h0A02;
        @(negedge clk);
        check("b2b.A_rsp", {31'b0, rsp_valid_o}, 32'd1);
        check("b2b.A_resp_ready", {31'b0, req_ready_o}, 32'd0);
        check("b2b.A_rdat", rsp_rdat_o, 32'h1111_1111);
        rd_value = 32'h2222_2222;
        @(negedge clk);
        check("b2b.idle_ready", {31'b0, req_ready_o}, 32'd1);
        check("b2b.idle_access", {31'b0, spr_access_o}, 32'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("b2b.B_access", {31'b0, spr_access_o}, 32'd1);
        check("b2b.B_addr", {16'b0, spr_addr_o}, 32'h0A02);
        @(negedge clk);
        check("b2b.B_rsp", {31'b0, rsp_valid_o}, 32'd1);
        check("b2b.B_rdat", rsp_rdat_o, 32'h2222_2222);

`ifdef MOR1KX_SPR_INITIATOR_TIMEOUT_EN
        run_txn("tmo_noack", 1'b0, 16'h5000, 32'h0, 100000, 32'h0, 4, 32'h0, 1'b1);
        run_txn("tmo_ack_last", 1'b0, 16'h5000, 32'h0, 3, 32'h0000_00A5, 4, 32'h0000_00A5, 1'b0);
`else
        run_txn("long_wait", 1'b0, 16'h5000, 32'h0, 999, 32'h0000_0777, 1000, 32'h0000_0777, 1'b0);
`endif

        // Reset during the second BUS cycle of a read that never gets acked.
        @(negedge clk);
        ack_after = 100000;
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        req_addr_i = 16'h4803;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        check("rst_abort.bus2_access", {31'b0, spr_access_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort.access", {31'b0, spr_access_o}, 32'd0);
        check("rst_abort.busy", {31'b0, busy_o}, 32'd0);
        check("rst_abort.rdat", rsp_rdat_o, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o) seen++;
            @(negedge clk);
        end
        check("rst_abort.no_rsp", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
